aludec_mc: RTL and testbench

//  Parametrised ALU control decoder with a multiply/divide sequencer, sitting between main decoder and datapath ALU/HI-LO unit.

---
 rtl/aludec_mc.sv | 127 ++++++++++++
 tb/tb_aludec_mc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aludec_mc.sv
// ALU control decoder with a fixed-latency multiply/divide sequencer.
// Decode is purely combinational; the MD FSM tracks one in-flight op and raises the HI/LO write strobe.
module aludec_mc #(
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              zext,
  output logic              shamt_sel,
  output logic              illegal,
  output logic [1:0]        hilo_rd,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              hilo_we,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       md_op_q, md_op_d;
  logic [3:0]       op;
  logic             rtype, md_instr;

  assign rtype    = (aluop == 3'b010);
  assign md_instr = valid_in && rtype && (funct[5:2] == 4'b0110);

  always_comb begin
    op        = 4'h2;
    shamt_sel = 1'b0;
    illegal   = 1'b0;
    hilo_rd   = 2'b00;
    zext      = (aluop == 3'b011) || (aluop == 3'b100) || (aluop == 3'b101);
    case (aluop)
      3'b000: op = 4'h2;
      3'b001: op = 4'h6;
      3'b011: op = 4'h1;
      3'b100: op = 4'h0;
      3'b101: op = 4'h3;
      3'b110: op = 4'h7;
      3'b111: op = 4'hB;
      default: begin
        case (funct)
          6'b100000, 6'b100001: op = 4'h2;
          6'b100010, 6'b100011: op = 4'h6;
          6'b100100: op = 4'h0;
          6'b100101: op = 4'h1;
          6'b100110: op = 4'h3;
          6'b100111: op = 4'h4;
          6'b101010: op = 4'h7;
          6'b101011: op = 4'h8;
          6'b000000: begin op = 4'h5; shamt_sel = 1'b1; end
          6'b000010: begin op = 4'h9; shamt_sel = 1'b1; end
          6'b000011: begin op = 4'hA; shamt_sel = 1'b1; end
          6'b010000: begin op = 4'h2; hilo_rd = 2'b01; end
          6'b010010: begin op = 4'h2; hilo_rd = 2'b10; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: op = 4'h2;
          default: begin op = 4'h0; illegal = valid_in; end
        endcase
      end
    endcase
  end

  always_comb begin
    alucontrol      = '0;
    alucontrol[3:0] = op;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_op_d  = md_op_q;
    md_start = 1'b0;
    hilo_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_instr && !flush) begin
          md_start = 1'b1;
          md_op_d  = funct[1:0];
          cnt_d    = funct[1] ? DIV_LAT : MULT_LAT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // flush takes priority over the final countdown step
        if (flush)               state_d = IDLE;
        else if (cnt_q == '0)    state_d = DONE;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        hilo_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      md_op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  assign md_op   = md_op_q;
  assign md_busy = (state_q != IDLE);
  assign stall   = valid_in && !flush && (state_q != IDLE) && (md_instr || (hilo_rd != 2'b00));

endmodule

// File: tb/tb_aludec_mc.sv
// Directed bench for aludec_mc: decode table, MD latency, stall, flush and async reset.
module tb_aludec_mc;

  logic       clk, reset_n, valid_in, flush;
  logic [2:0] aluop;
  logic [5:0] funct;
  logic [3:0] alucontrol;
  logic       zext, shamt_sel, illegal, md_start, md_busy, hilo_we, stall;
  logic [1:0] hilo_rd, md_op;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  localparam logic [5:0] F_MULT = 6'b011000, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MFHI = 6'b010000;

  aludec_mc #(.CTRL_W(4), .MULT_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
    .aluop(aluop), .funct(funct), .alucontrol(alucontrol), .zext(zext),
    .shamt_sel(shamt_sel), .illegal(illegal), .hilo_rd(hilo_rd),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .hilo_we(hilo_we), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic fl, input logic [2:0] aop, input logic [5:0] fn);
    valid_in = v; flush = fl; aluop = aop; funct = fn;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv(1'b0, 1'b0, 3'b000, 6'b0);
    #3;
    check("rst_busy", md_busy, 0);
    check("rst_we", hilo_we, 0);
    check("rst_op", md_op, 0);
    #9 reset_n = 1'b1;
    next_cycle();

    // Combinational decode
    drv(1'b1, 1'b0, 3'b010, 6'b100111); #1;
    check("nor_ctl", alucontrol, 4'h4); check("nor_sh", shamt_sel, 0); check("nor_ill", illegal, 0);
    drv(1'b1, 1'b0, 3'b010, 6'b101011); #1;
    check("sltu_ctl", alucontrol, 4'h8); check("sltu_sh", shamt_sel, 0);
    drv(1'b1, 1'b0, 3'b010, 6'b000011); #1;
    check("sra_ctl", alucontrol, 4'hA); check("sra_sh", shamt_sel, 1);
    drv(1'b1, 1'b0, 3'b010, 6'b111111); #1;
    check("bad_ill", illegal, 1); check("bad_ctl", alucontrol, 4'h0);
    drv(1'b0, 1'b0, 3'b010, 6'b111111); #1;
    check("bad_noval", illegal, 0);
    drv(1'b1, 1'b0, 3'b011, 6'b111111); #1;
    check("ori_ctl", alucontrol, 4'h1); check("ori_z", zext, 1);
    drv(1'b1, 1'b0, 3'b101, 6'b0); #1;
    check("xori_ctl", alucontrol, 4'h3); check("xori_z", zext, 1);
    drv(1'b1, 1'b0, 3'b111, 6'b0); #1;
    check("lui_ctl", alucontrol, 4'hB); check("lui_z", zext, 0);
    drv(1'b1, 1'b0, 3'b010, F_MFLO); #1;
    check("mflo_rd", hilo_rd, 2'b10); check("mflo_ctl", alucontrol, 4'h2); check("mflo_ill", illegal, 0);
    drv(1'b1, 1'b0, 3'b010, F_MFHI); #1;
    check("mfhi_rd", hilo_rd, 2'b01); check("mfhi_stall", stall, 0);
    drv(1'b0, 1'b0, 3'b000, 6'b0);
    next_cycle();

    // mult at cycle 0, mflo at 2 (stalls) and 6 (idle again)
    for (int c = 0; c <= 7; c++) begin
      if (c == 0)                drv(1'b1, 1'b0, 3'b010, F_MULT);
      else if (c == 2 || c == 6) drv(1'b1, 1'b0, 3'b010, F_MFLO);
      else                       drv(1'b0, 1'b0, 3'b000, 6'b0);
      @(negedge clk);
      check($sformatf("mul_start@%0d", c), md_start, (c == 0));
      check($sformatf("mul_busy@%0d", c), md_busy, (c >= 1 && c <= 5));
      check($sformatf("mul_we@%0d", c), hilo_we, (c == 5));
      check($sformatf("mul_stall@%0d", c), stall, (c == 2));
      if (c == 3) check("mul_op", md_op, 2'b00);
      next_cycle();
    end

    // divu at 0, adds follow, second div from 3 held until accepted at 35
    for (int c = 0; c <= 36; c++) begin
      if (c == 0)      drv(1'b1, 1'b0, 3'b010, F_DIVU);
      else if (c >= 3 && c <= 35) drv(1'b1, 1'b0, 3'b010, F_DIV);
      else             drv(1'b1, 1'b0, 3'b000, 6'b0);
      @(negedge clk);
      check($sformatf("div_start@%0d", c), md_start, (c == 0 || c == 35));
      check($sformatf("div_we@%0d", c), hilo_we, (c == 34));
      check($sformatf("div_stall@%0d", c), stall, (c >= 3 && c <= 34));
      check($sformatf("div_busy@%0d", c), md_busy, (c >= 1 && c <= 34) || c == 36);
      if (c == 5)  check("divu_op", md_op, 2'b11);
      if (c == 36) check("div_op", md_op, 2'b10);
      next_cycle();
    end
    drv(1'b0, 1'b0, 3'b000, 6'b0);
    for (int c = 0; c < 40; c++) next_cycle();
    check("drain_busy", md_busy, 0);

    // div accepted at 0, flushed at 10
    for (int c = 0; c <= 40; c++) begin
      if (c == 0)       drv(1'b1, 1'b0, 3'b010, F_DIV);
      else if (c == 10) drv(1'b0, 1'b1, 3'b000, 6'b0);
      else              drv(1'b0, 1'b0, 3'b000, 6'b0);
      @(negedge clk);
      check($sformatf("fl_busy@%0d", c), md_busy, (c >= 1 && c <= 10));
      check($sformatf("fl_we@%0d", c), hilo_we, 0);
      next_cycle();
    end
    drv(1'b1, 1'b1, 3'b010, F_MULT);
    @(negedge clk);
    check("flmul_start", md_start, 0);
    check("flmul_stall", stall, 0);
    next_cycle();
    drv(1'b0, 1'b0, 3'b000, 6'b0);
    @(negedge clk);
    check("flmul_busy", md_busy, 0);
    next_cycle();

    // async reset mid-BUSY, then a full-latency mult
    for (int c = 0; c <= 2; c++) begin
      if (c == 0) drv(1'b1, 1'b0, 3'b010, F_MULT);
      else        drv(1'b0, 1'b0, 3'b000, 6'b0);
      if (c == 2) begin
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", md_busy, 0);
        check("arst_we", hilo_we, 0);
        #1 reset_n = 1'b1;
      end
      next_cycle();
    end
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) drv(1'b1, 1'b0, 3'b010, F_MULT);
      else        drv(1'b0, 1'b0, 3'b000, 6'b0);
      @(negedge clk);
      check($sformatf("rs_busy@%0d", c), md_busy, (c >= 1 && c <= 5));
      check($sformatf("rs_we@%0d", c), hilo_we, (c == 5));
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
